// File: rtl/wb_sequencer_if.sv
// Write-back sequencer bus: phase-5 start request, datapath sources,
// external input handshake and register-file write port.
interface wb_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RA_W  = 3
);
  logic             wb_start;
  logic [1:0]       wb_kind;
  logic [RA_W-1:0]  wb_dest;
  logic [WIDTH-1:0] dr_data;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       src_sel;
  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             wb_done;
  logic             busy;
  logic             start_err;
  logic [15:0]      stall_cnt;

  modport master (
    output wb_start, wb_kind, wb_dest, dr_data, mem_data, in_data, in_valid,
    input  in_ready, src_sel, rf_we, rf_waddr, rf_wdata, wb_done, busy,
           start_err, stall_cnt
  );

  modport slave (
    input  wb_start, wb_kind, wb_dest, dr_data, mem_data, in_data, in_valid,
    output in_ready, src_sel, rf_we, rf_waddr, rf_wdata, wb_done, busy,
           start_err, stall_cnt
  );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back phase controller: picks the write-back source, handshakes the
// external input for IN, and issues one register-file write per instruction.
module wb_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RA_W  = 3
) (
  input  logic          clk,
  input  logic          reset,
  wb_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_WAIT_IN = 2'd2,
    S_DONE_NW = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       src_sel_q, src_sel_d;
  logic             rf_we_q, rf_we_d;
  logic [RA_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             wb_done_q, wb_done_d;
  logic             start_err_q, start_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept_c;
  logic xfer_c;

  assign accept_c = bus.wb_start && (state_q == S_IDLE);
  assign xfer_c   = (state_q == S_WAIT_IN) && bus.in_valid && in_ready_q;

  // State and output registers; reset wins over everything, including a
  // transfer on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      src_sel_q   <= 2'd0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      wb_done_q   <= 1'b0;
      start_err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      src_sel_q   <= src_sel_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      wb_done_q   <= wb_done_d;
      start_err_q <= start_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.wb_start) begin
          unique case (bus.wb_kind)
            2'b01, 2'b10: state_d = S_WRITE;
            2'b11:        state_d = S_WAIT_IN;
            default:      state_d = S_DONE_NW;
          endcase
        end
      end
      S_WAIT_IN: begin
        if (xfer_c) state_d = S_WRITE;
      end
      S_WRITE, S_DONE_NW: state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic; strobes are decoded from the next state so
  // they line up with the state they belong to.
  always_comb begin
    in_ready_d  = (state_d == S_WAIT_IN);
    rf_we_d     = (state_d == S_WRITE);
    wb_done_d   = (state_d == S_WRITE) || (state_d == S_DONE_NW);
    src_sel_d   = src_sel_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    start_err_d = start_err_q || (bus.wb_start && (state_q != S_IDLE));
    stall_cnt_d = stall_cnt_q;

    if ((state_q == S_WAIT_IN) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    if (accept_c) begin
      rf_waddr_d = bus.wb_dest;
      unique case (bus.wb_kind)
        2'b01: begin
          rf_wdata_d = bus.dr_data;
          src_sel_d  = 2'd0;
        end
        2'b10: begin
          rf_wdata_d = bus.mem_data;
          src_sel_d  = 2'd1;
        end
        2'b11: src_sel_d = 2'd2;
        default: ;
      endcase
    end

    if (xfer_c) rf_wdata_d = bus.in_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.src_sel   = src_sel_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.wb_done   = wb_done_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.start_err = start_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, reset/saturation sequences
// and randomized transactions against a transaction-level model.
module tb_wb_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_sequencer_if #(.WIDTH(16), .RA_W(3)) bus ();

  wb_sequencer #(.WIDTH(16), .RA_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  dest;
    logic [15:0] dr;
    logic [15:0] mem;
    logic [15:0] ind;
    int          waitc;
    bit          bad;
    logic [15:0] e_data;
    logic [1:0]  e_src;
    logic [15:0] e_stall;
    logic        e_err;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One complete write-back phase; expectations are supplied by the caller.
  task automatic run_txn(input logic [1:0] k, input logic [2:0] d,
                         input logic [15:0] dr, input logic [15:0] mem,
                         input logic [15:0] ind, input int waitc, input bit bad,
                         input logic [15:0] e_data, input logic [1:0] e_src,
                         input logic [15:0] e_stall);
    bus.wb_start = 1'b1;
    bus.wb_kind  = k;
    bus.wb_dest  = d;
    bus.dr_data  = dr;
    bus.mem_data = mem;
    bus.in_valid = 1'($urandom_range(1));
    bus.in_data  = 16'($urandom);
    tick();
    bus.wb_start = bad;
    bus.wb_kind  = 2'($urandom);
    bus.wb_dest  = 3'($urandom);
    bus.dr_data  = 16'($urandom);
    bus.mem_data = 16'h0000;
    if (k == 2'b11) begin
      chk("in_ready_rise", 32'(bus.in_ready), 32'd1);
      chk("busy_wait", 32'(bus.busy), 32'd1);
      for (int i = 0; i < waitc; i++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        tick();
        bus.wb_start = 1'b0;
        chk("in_ready_hold", 32'(bus.in_ready), 32'd1);
        chk("we_during_wait", 32'(bus.rf_we), 32'd0);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ind;
      tick();
      bus.wb_start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
    end
    chk("rf_we", 32'(bus.rf_we), (k != 2'b00) ? 32'd1 : 32'd0);
    chk("wb_done", 32'(bus.wb_done), 32'd1);
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(d));
    chk("rf_wdata", 32'(bus.rf_wdata), 32'(e_data));
    chk("src_sel", 32'(bus.src_sel), 32'(e_src));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd1);
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(e_stall));
    tick();
    bus.wb_start = 1'b0;
    chk("rf_we_after", 32'(bus.rf_we), 32'd0);
    chk("wb_done_after", 32'(bus.wb_done), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("rf_wdata_hold", 32'(bus.rf_wdata), 32'(e_data));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] m_data, m_stall, e_data, dr, mem, ind;
    logic [1:0]  m_src, k, e_src;
    logic [2:0]  d;
    logic        m_err;
    int          w;
    bit          bad;

    bus.wb_start = 1'b0;
    bus.wb_kind  = 2'b00;
    bus.wb_dest  = 3'd0;
    bus.dr_data  = 16'h0;
    bus.mem_data = 16'h0;
    bus.in_data  = 16'h0;
    bus.in_valid = 1'b0;

    vecs[0] = '{2'b01, 3'd5, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0, 16'h1234, 2'd0, 16'd0, 1'b0};
    vecs[1] = '{2'b10, 3'd2, 16'h5555, 16'hBEEF, 16'h0000, 0, 1'b0, 16'hBEEF, 2'd1, 16'd0, 1'b0};
    vecs[2] = '{2'b11, 3'd7, 16'h1111, 16'h2222, 16'h00A5, 4, 1'b0, 16'h00A5, 2'd2, 16'd5, 1'b0};
    vecs[3] = '{2'b00, 3'd3, 16'h3333, 16'h4444, 16'h0000, 0, 1'b0, 16'h00A5, 2'd2, 16'd5, 1'b0};
    vecs[4] = '{2'b01, 3'd1, 16'hFFFF, 16'h6666, 16'h0000, 0, 1'b1, 16'hFFFF, 2'd0, 16'd5, 1'b1};
    vecs[5] = '{2'b11, 3'd0, 16'h7777, 16'h8888, 16'h8001, 0, 1'b1, 16'h8001, 2'd2, 16'd6, 1'b1};

    // Reset state
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_wb_done", 32'(bus.wb_done), 32'd0);
    chk("rst_start_err", 32'(bus.start_err), 32'd0);
    chk("rst_src_sel", 32'(bus.src_sel), 32'd0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].kind, vecs[i].dest, vecs[i].dr, vecs[i].mem, vecs[i].ind,
              vecs[i].waitc, vecs[i].bad, vecs[i].e_data, vecs[i].e_src, vecs[i].e_stall);
      chk("vec_start_err", 32'(bus.start_err), 32'(vecs[i].e_err));
    end

    // Reset mid-handshake with in_valid on the same edge
    bus.wb_start = 1'b1;
    bus.wb_kind  = 2'b11;
    bus.wb_dest  = 3'd4;
    tick();
    bus.wb_start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("midrst_stall", 32'(bus.stall_cnt), 32'd0);
    chk("midrst_err", 32'(bus.start_err), 32'd0);
    chk("midrst_wdata", 32'(bus.rf_wdata), 32'd0);
    tick();
    chk("midrst_rf_we2", 32'(bus.rf_we), 32'd0);
    chk("midrst_done2", 32'(bus.wb_done), 32'd0);

    // Randomized transactions against the transaction-level model
    m_data = 16'h0; m_src = 2'd0; m_stall = 16'h0; m_err = 1'b0;
    for (int n = 0; n < 200; n++) begin
      for (int g = 0; g < int'($urandom_range(2)); g++) begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = 16'($urandom);
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        chk("idle_rf_we", 32'(bus.rf_we), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
      end
      k   = 2'($urandom);
      d   = 3'($urandom);
      dr  = 16'($urandom);
      mem = 16'($urandom);
      ind = 16'($urandom);
      w   = int'($urandom_range(6));
      bad = ($urandom_range(7) == 0);
      case (k)
        2'b01: begin e_data = dr;  e_src = 2'd0; end
        2'b10: begin e_data = mem; e_src = 2'd1; end
        2'b11: begin e_data = ind; e_src = 2'd2; end
        default: begin e_data = m_data; e_src = m_src; end
      endcase
      if (k == 2'b11) begin
        m_stall = (32'(m_stall) + 32'(w) + 1 > 32'hFFFF) ? 16'hFFFF : 16'(m_stall + 16'(w) + 16'd1);
      end
      run_txn(k, d, dr, mem, ind, w, bad, e_data, e_src, m_stall);
      m_data = e_data;
      m_src  = e_src;
      m_err  = m_err | bad;
      chk("rand_start_err", 32'(bus.start_err), 32'(m_err));
    end

    // Stall counter saturation, then a normal transfer
    do_reset();
    run_txn(2'b11, 3'd6, 16'h0, 16'h0, 16'h1357, 70000, 1'b0, 16'h1357, 2'd2, 16'hFFFF);
    chk("sat_stall_hold", 32'(bus.stall_cnt), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
